cla_wide_add_seq: RTL

Multi-cycle wide-operand adder/subtractor controller built around a single 16-bit carry-lookahead slice. It accepts one WIDTH-bit operand pair per transaction over a valid/ready handshake. It then sequences the operands through the slice one 16-bit word per cycle, least-significant word first, chaining the carry in a register. Sum, carry-out and signed overflow are returned over a second valid/ready handshake. It sits in the butterfly post-processing path, where 64-bit twiddle/accumulator additions must reuse one shared CLA16 instead of a full-width adder.

---
 rtl/cla_wide_add_seq_pkg.sv | 17 +
 rtl/cla_wide_add_seq_cla16.sv | 45 ++++
 rtl/cla_wide_add_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/cla_wide_add_seq_pkg.sv
// rtl/cla_wide_add_seq_pkg.sv - shared constants, state encoding and sizing helper for the wide CLA sequencer
package cla_wide_add_seq_pkg;

    localparam int CLA_SEG = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Word index width; a one-bit counter is kept even when WORDS would need zero bits.
    function automatic int idx_width(input int words);
        return (words > 2) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_wide_add_seq_cla16.sv
// rtl/cla_wide_add_seq_cla16.sv - two-level 16-bit carry-lookahead adder slice with group generate/propagate
module cla_wide_add_seq_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        g_out,
    output logic        p_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [3:0]  bc;

    // Carries into positions 1..3 of a 4-wide group, all computed in parallel from ci.
    function automatic logic [2:0] lookahead(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
        logic [2:0] co;
        co[0] = gi[0] | (pi[0] & ci);
        co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
        return co;
    endfunction

    function automatic logic group_g(input logic [3:0] gi, input logic [3:0] pi);
        return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    endfunction

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        assign bg[k]      = group_g(g[4*k +: 4], p[4*k +: 4]);
        assign bp[k]      = &p[4*k +: 4];
        assign c[4*k +: 4] = {lookahead(g[4*k +: 4], p[4*k +: 4], bc[k]), bc[k]};
    end

    assign bc    = {lookahead(bg, bp, c_in), c_in};
    assign g_out = group_g(bg, bp);
    assign p_out = &bp;
    assign s     = p ^ c;

endmodule

// File: rtl/cla_wide_add_seq.sv
// rtl/cla_wide_add_seq.sv - WIDTH-bit add/subtract sequenced one 16-bit word per cycle through a shared CLA16
module cla_wide_add_seq
    import cla_wide_add_seq_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int WIDTH = CLA_SEG * WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int               IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;

    logic [CLA_SEG-1:0] slice_sum;
    logic               slice_g;
    logic               slice_p;
    logic               carry_next;

    cla_wide_add_seq_cla16 u_CLA16 (
        .a     (a_reg[idx*CLA_SEG +: CLA_SEG]),
        .b     (b_reg[idx*CLA_SEG +: CLA_SEG]),
        .c_in  (carry_reg),
        .s     (slice_sum),
        .g_out (slice_g),
        .p_out (slice_p)
    );

    assign carry_next = slice_g | (slice_p & carry_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= a_in;
                        b_reg     <= sub ? ~b_in : b_in;
                        carry_reg <= sub | c_in;
                        idx       <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    sum[idx*CLA_SEG +: CLA_SEG] <= slice_sum;
                    carry_reg                   <= carry_next;
                    if (idx == LAST_IDX) begin
                        c_out     <= carry_next;
                        // Carry into the MSB differs from carry out exactly when signed overflow occurs.
                        ovf       <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[CLA_SEG-1] ^ carry_next;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
